// File: rtl/alu_sequencer.sv
// alu_sequencer: issue/execute/write-back controller for the 16-bit ALU.
// Accepts one instruction at a time over valid/ready. It holds the decoded
// ALU controls for the operation latency, then emits a one-cycle write-back.
// Optional feature macro: ALU_SEQ_PERF_EN adds the retired_cnt output.
module alu_sequencer #(
    parameter int DATA_W     = 16,
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [3:0]        rs1_addr,
    output logic [3:0]        rs2_addr,
    input  logic              rs2_zero,
    output logic              alu_en,
    output logic [2:0]        alu_op,
    output logic              alu_sub,
    input  logic [DATA_W-1:0] alu_result,
    output logic              wb_en,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              div_zero,
    output logic              illegal,
`ifdef ALU_SEQ_PERF_EN
    output logic [15:0]       retired_cnt,
`endif
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        TRAP = 2'd3
    } state_t;

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q;
    logic       first_q;
    logic       is_div_q;

    logic       hs;
    logic       div_abort;
    logic       dec_legal;
    logic [2:0] dec_op;
    logic       dec_sub;
    logic [3:0] dec_last;

    assign instr_ready = (state_q == IDLE) || (state_q == WB);
    assign busy        = (state_q != IDLE);
    assign hs          = instr_valid && instr_ready;

    // A zero divisor seen in the first EXEC cycle of a DIV skips the remaining latency.
    assign div_abort = (state_q == EXEC) && first_q && is_div_q && rs2_zero;

    // Decode the offered opcode into ALU controls and last counter value.
    always_comb begin
        dec_legal = 1'b1;
        dec_op    = 3'b000;
        dec_sub   = 1'b0;
        dec_last  = 4'd0;
        case (instr[15:12])
            4'b0000: dec_op = 3'b000;
            4'b0001: begin
                dec_op  = 3'b001;
                dec_sub = 1'b1;
            end
            4'b0010: dec_op = 3'b010;
            4'b0011: dec_op = 3'b011;
            4'b0100: begin
                dec_op   = 3'b100;
                dec_last = MUL_LAST;
            end
            4'b0101: begin
                dec_op   = 3'b101;
                dec_last = DIV_LAST;
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Next-state logic for the issue/execute/write-back sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (hs) state_d = dec_legal ? EXEC : TRAP;
            end
            EXEC: begin
                if (div_abort || (cnt_q == 4'd0)) state_d = WB;
            end
            WB: begin
                if (hs) state_d = dec_legal ? EXEC : TRAP;
                else    state_d = IDLE;
            end
            TRAP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Latch operands and controls on a legal handshake; run the latency counter in EXEC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op   <= 3'b000;
            alu_sub  <= 1'b0;
            rs1_addr <= 4'd0;
            rs2_addr <= 4'd0;
            wb_addr  <= 4'd0;
            cnt_q    <= 4'd0;
            first_q  <= 1'b0;
            is_div_q <= 1'b0;
        end else if (hs && dec_legal) begin
            alu_op   <= dec_op;
            alu_sub  <= dec_sub;
            rs1_addr <= instr[7:4];
            rs2_addr <= instr[3:0];
            wb_addr  <= instr[11:8];
            cnt_q    <= dec_last;
            first_q  <= 1'b1;
            is_div_q <= (instr[15:12] == 4'b0101);
        end else if (state_q == EXEC) begin
            first_q <= 1'b0;
            if (cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
        end
    end

    // Registered strobes track the state being entered so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_en   <= 1'b0;
            wb_en    <= 1'b0;
            illegal  <= 1'b0;
            div_zero <= 1'b0;
            wb_data  <= '0;
        end else begin
            alu_en   <= (state_d == EXEC);
            wb_en    <= (state_d == WB);
            illegal  <= (state_d == TRAP);
            div_zero <= (state_d == WB) && div_abort;
            if ((state_q == EXEC) && (state_d == WB))
                wb_data <= div_abort ? {DATA_W{1'b1}} : alu_result;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    // Count retired instructions, one per write-back, wrapping at 16 bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)               retired_cnt <= 16'd0;
        else if (state_d == WB)   retired_cnt <= retired_cnt + 16'd1;
    end
`endif

endmodule
